// File: rtl/vend_pkg.sv
// vend_pkg: shared state, coin encoding and coin value helper.
// Stock tracking in vend_controller is enabled by VEND_STOCK_EN.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CREDIT,
        DISPENSE,
        CHANGE
    } state_t;

    typedef enum logic [1:0] {
        COIN_BAD = 2'b00,
        COIN_5C  = 2'b01,
        COIN_10C = 2'b10,
        COIN_25C = 2'b11
    } coin_e;

    // Coin value in 5-cent units; invalid coins are worth nothing
    function automatic logic [2:0] coin_units(input logic [1:0] v);
        logic [2:0] u;
        unique case (coin_e'(v))
            COIN_5C:  u = 3'd1;
            COIN_10C: u = 3'd2;
            COIN_25C: u = 3'd5;
            default:  u = 3'd0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/vend_if.sv
// vend_if: coin, keypad and actuator handshakes of the controller.
// master is the front end / actuator side, slave is the controller.
interface vend_if #(
    parameter int N_SLOTS = 4
);

    logic                       coin_valid;
    logic [1:0]                 coin_val;
    logic                       coin_ready;
    logic                       coin_reject;
    logic                       sel_valid;
    logic [$clog2(N_SLOTS)-1:0] sel_slot;
    logic                       cancel;
    logic                       disp_req;
    logic [$clog2(N_SLOTS)-1:0] disp_slot;
    logic                       disp_ack;
    logic                       chg_req;
    logic                       chg_ack;

    modport master (
        output coin_valid, coin_val,
        output sel_valid, sel_slot, cancel,
        output disp_ack, chg_ack,
        input  coin_ready, coin_reject,
        input  disp_req, disp_slot, chg_req
    );

    modport slave (
        input  coin_valid, coin_val,
        input  sel_valid, sel_slot, cancel,
        input  disp_ack, chg_ack,
        output coin_ready, coin_reject,
        output disp_req, disp_slot, chg_req
    );

endinterface

// File: rtl/vend_stock.sv
// vend_stock: per-slot stock counters with restock load and empty flags.
// Only instantiated when VEND_STOCK_EN is defined.
module vend_stock #(
    parameter int N_SLOTS = 4,
    parameter int STOCK_W = 4,
    parameter int SLOT_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dec,
    input  logic [SLOT_W-1:0]  dec_slot,
    input  logic               load,
    input  logic [SLOT_W-1:0]  load_slot,
    output logic [N_SLOTS-1:0] empty
);

    localparam logic [STOCK_W-1:0] FULL = '1;

    logic [STOCK_W-1:0] cnt_q [N_SLOTS];

    // Restock reloads a slot to full; each completed vend removes one item
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                cnt_q[i] <= FULL;
            end
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                if (load && load_slot == SLOT_W'(i)) begin
                    cnt_q[i] <= FULL;
                end else if (dec && dec_slot == SLOT_W'(i)
                             && cnt_q[i] != '0) begin
                    cnt_q[i] <= cnt_q[i] - STOCK_W'(1);
                end
            end
        end
    end

    // Empty flags gate the selection check
    always_comb begin
        empty = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            empty[i] = (cnt_q[i] == '0);
        end
    end

endmodule

// File: rtl/vend_controller.sv
// vend_controller: credit, selection, dispense and change sequencing.
// Define VEND_STOCK_EN to enable per-slot stock, restock and err_stock.
module vend_controller
    import vend_pkg::*;
#(
    parameter int N_SLOTS  = 4,
    parameter int CREDIT_W = 6,
    parameter int STOCK_W  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    vend_if.slave                        bus,
    input  logic [N_SLOTS*CREDIT_W-1:0]  price_tbl,
    output logic [CREDIT_W-1:0]          credit,
    output logic                         err_funds,
    input  logic                         restock,
    input  logic [$clog2(N_SLOTS)-1:0]   restock_slot,
    output logic                         err_stock
);

    localparam int SLOT_W = $clog2(N_SLOTS);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                rej_q, rej_d;
    logic                funds_q, funds_d;
    logic                nostk_q, nostk_d;

    logic                sel_ok;
    logic                sel_empty;
    logic [CREDIT_W-1:0] sel_price;
    logic [CREDIT_W-1:0] disp_price;
    logic [N_SLOTS-1:0]  empty;
    logic [2:0]          units;
    logic [CREDIT_W:0]   coin_sum;
    logic                open;
    logic                vend_done;

    assign open      = (state_q == IDLE) || (state_q == CREDIT);
    assign vend_done = (state_q == DISPENSE) && bus.disp_ack;
    assign units     = coin_units(bus.coin_val);
    assign coin_sum  = {1'b0, credit_q}
                     + {{(CREDIT_W-2){1'b0}}, units};

`ifdef VEND_STOCK_EN
    vend_stock #(
        .N_SLOTS (N_SLOTS),
        .STOCK_W (STOCK_W),
        .SLOT_W  (SLOT_W)
    ) u_stock (
        .clk       (clk),
        .rst_n     (rst_n),
        .dec       (vend_done),
        .dec_slot  (slot_q),
        .load      (restock && state_q == IDLE),
        .load_slot (restock_slot),
        .empty     (empty)
    );
`else
    localparam int UNUSED_STOCK_W = STOCK_W;
    logic unused_restock;
    assign unused_restock = ^{restock, restock_slot};
    assign empty = '0;
`endif

    // Price and stock lookup for the keyed slot and the latched slot
    always_comb begin
        sel_ok     = 1'b0;
        sel_empty  = 1'b0;
        sel_price  = '0;
        disp_price = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (bus.sel_slot == SLOT_W'(i)) begin
                sel_ok    = 1'b1;
                sel_empty = empty[i];
                sel_price = price_tbl[i*CREDIT_W +: CREDIT_W];
            end
            if (slot_q == SLOT_W'(i)) begin
                disp_price = price_tbl[i*CREDIT_W +: CREDIT_W];
            end
        end
    end

    // Next state: cancel beats selection beats coin while taking money
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        slot_d   = slot_q;
        rej_d    = 1'b0;
        funds_d  = 1'b0;
        nostk_d  = 1'b0;
        unique case (state_q)
            IDLE, CREDIT: begin
                if (bus.cancel) begin
                    if (state_q == CREDIT) begin
                        state_d = CHANGE;
                    end
                end else if (bus.sel_valid) begin
                    if (sel_empty) begin
                        nostk_d = 1'b1;
                    end else if (!sel_ok || credit_q < sel_price) begin
                        funds_d = 1'b1;
                    end else begin
                        slot_d  = bus.sel_slot;
                        state_d = DISPENSE;
                    end
                end else if (bus.coin_valid) begin
                    if (units == '0 || coin_sum[CREDIT_W]) begin
                        rej_d = 1'b1;
                    end else begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = CREDIT;
                    end
                end
            end
            DISPENSE: begin
                if (bus.disp_ack) begin
                    if (credit_q > disp_price) begin
                        credit_d = credit_q - disp_price;
                        state_d  = CHANGE;
                    end else begin
                        credit_d = '0;
                        state_d  = IDLE;
                    end
                end
            end
            CHANGE: begin
                if (credit_q == '0) begin
                    state_d = IDLE;
                end else if (bus.chg_ack) begin
                    credit_d = credit_q - CREDIT_W'(1);
                    if (credit_q == CREDIT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, credit, latched slot and error pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            credit_q <= '0;
            slot_q   <= '0;
            rej_q    <= 1'b0;
            funds_q  <= 1'b0;
            nostk_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            slot_q   <= slot_d;
            rej_q    <= rej_d;
            funds_q  <= funds_d;
            nostk_q  <= nostk_d;
        end
    end

    assign bus.coin_ready  = open && !bus.cancel && !bus.sel_valid;
    assign bus.coin_reject = rej_q;
    assign bus.disp_req    = (state_q == DISPENSE);
    assign bus.disp_slot   = slot_q;
    assign bus.chg_req     = (state_q == CHANGE) && (credit_q != '0);
    assign credit          = credit_q;
    assign err_funds       = funds_q;
    assign err_stock       = nostk_q;

endmodule
